// File: rtl/connector_test_pkg.sv
// Shared types and arithmetic helpers for the connector test sequencer.
package connector_test_pkg;

    // Helpers compute in a wide type; callers truncate to their bus width.
    localparam int CALC_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Period of channel i: the base period scaled by the channel number plus one.
    function automatic logic [CALC_W-1:0] chan_period(input logic [CALC_W-1:0] i,
                                                      input logic [CALC_W-1:0] koef);
        return koef * (i + 64'd1);
    endfunction

    // Test window: room for the expected pulses plus loopback settling time.
    function automatic logic [CALC_W-1:0] window_len(input logic [CALC_W-1:0] period,
                                                     input logic [CALC_W-1:0] pulses,
                                                     input logic [CALC_W-1:0] settle);
        return pulses * period + settle;
    endfunction

endpackage

// File: rtl/connector_test_sequencer_if.sv
// Control, sense and generator-bus signals of the connector test sequencer.
interface connector_test_sequencer_if #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              start;
    logic              abort;
    logic [NUM_CH-1:0] chan_en;
    logic [NUM_CH-1:0] sense_in;
    logic [NUM_CH-1:0] gen_enable;
    logic [NUM_CH-1:0] gen_reset;
    logic [WIDTH-1:0]  gen_delay;
    logic [WIDTH-1:0]  gen_duration;
    logic [WIDTH-1:0]  gen_period;
    logic [CH_W-1:0]   cur_chan;
    logic [CNT_W-1:0]  edge_count;
    logic              busy;
    logic              done;
    logic [NUM_CH-1:0] pass_mask;
    logic [NUM_CH-1:0] fail_mask;

    modport master (
        output start, abort, chan_en, sense_in,
        input  gen_enable, gen_reset, gen_delay, gen_duration, gen_period,
        input  cur_chan, edge_count, busy, done, pass_mask, fail_mask
    );

    modport slave (
        input  start, abort, chan_en, sense_in,
        output gen_enable, gen_reset, gen_delay, gen_duration, gen_period,
        output cur_chan, edge_count, busy, done, pass_mask, fail_mask
    );
endinterface

// File: rtl/sense_sync_edge.sv
// One sense channel: two-flop synchroniser followed by a registered rising-edge detector.
module sense_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic sense,
    output logic rise
);
    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic rise_r;

    // Synchronise the asynchronous line and emit a one-cycle pulse per rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            meta_r <= sense;
            sync_r <= meta_r;
            prev_r <= sync_r;
            rise_r <= sync_r & ~prev_r;
        end
    end

    assign rise = rise_r;
endmodule

// File: rtl/connector_test_sequencer.sv
// Steps through enabled connector channels, pulses each generator for a timed
// window, counts looped-back edges and records pass/fail per channel.
module connector_test_sequencer
    import connector_test_pkg::*;
#(
    parameter int NUM_CH                 = 8,
    parameter int WIDTH                  = 32,
    parameter int unsigned KOEF_T        = 250_000,
    parameter int unsigned PULSES_PER_CH = 4,
    parameter int unsigned SETTLE        = 16,
    parameter int CNT_W                  = 8
) (
    input logic clk,
    input logic reset,
    connector_test_sequencer_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [63:0] WORST_WINDOW =
        64'(NUM_CH) * 64'(KOEF_T) * 64'(PULSES_PER_CH) + 64'(SETTLE);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    // The longest window must fit the timer and configuration buses.
    if (WIDTH < 64 && WORST_WINDOW >= (64'd1 << WIDTH)) begin : g_width_check
        $error("connector_test_sequencer: window length overflows WIDTH");
    end

    state_t            state_r, state_s;
    logic [CH_W-1:0]   cur_chan_r, cur_chan_s;
    logic [CH_W-1:0]   first_idx_s, next_idx_s;
    logic              first_found_s, next_found_s;
    logic [NUM_CH-1:0] rise_s;
    logic [WIDTH-1:0]  period_s, window_s, timer_r;
    logic [WIDTH-1:0]  gen_period_r, gen_duration_r;
    logic [CNT_W-1:0]  edge_count_r;
    logic [NUM_CH-1:0] gen_enable_r, gen_reset_r, pass_mask_r, fail_mask_r;
    logic              busy_r, done_r;
    logic              start_ok_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sense
        sense_sync_edge u_sense (
            .clk   (clk),
            .reset (reset),
            .sense (bus.sense_in[g]),
            .rise  (rise_s[g])
        );
    end

    assign period_s   = WIDTH'(chan_period(64'(cur_chan_s), 64'(KOEF_T)));
    assign window_s   = WIDTH'(window_len(64'(gen_period_r), 64'(PULSES_PER_CH), 64'(SETTLE)));
    assign start_ok_s = bus.start & ~bus.abort & ((state_r == ST_IDLE) | (state_r == ST_DONE));

    // Locate the lowest enabled channel and the next enabled channel above cur_chan.
    always_comb begin
        first_found_s = 1'b0;
        first_idx_s   = '0;
        next_found_s  = 1'b0;
        next_idx_s    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            first_found_s = bus.chan_en[i] ? 1'b1 : first_found_s;
            first_idx_s   = bus.chan_en[i] ? CH_W'(i) : first_idx_s;
            next_found_s  = (bus.chan_en[i] && (i > int'(cur_chan_r))) ? 1'b1 : next_found_s;
            next_idx_s    = (bus.chan_en[i] && (i > int'(cur_chan_r))) ? CH_W'(i) : next_idx_s;
        end
    end

    // Next-state and next-channel selection; abort overrides every transition.
    always_comb begin
        state_s    = state_r;
        cur_chan_s = cur_chan_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    if (first_found_s) begin
                        state_s    = ST_LOAD;
                        cur_chan_s = first_idx_s;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: state_s = ST_RUN;
            ST_RUN: begin
                if (timer_r <= WIDTH'(1)) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_CHECK: begin
                if (next_found_s) begin
                    state_s    = ST_LOAD;
                    cur_chan_s = next_idx_s;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        if (bus.abort) begin
            state_s    = ST_IDLE;
            cur_chan_s = cur_chan_r;
        end else begin
            state_s = state_s;
        end
    end

    // State register plus outputs registered from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cur_chan_r     <= '0;
            gen_enable_r   <= '0;
            gen_reset_r    <= '0;
            gen_period_r   <= '0;
            gen_duration_r <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r      <= state_s;
            cur_chan_r   <= cur_chan_s;
            gen_enable_r <= (state_s == ST_RUN)  ? (ONE_HOT0 << cur_chan_s) : '0;
            gen_reset_r  <= (state_s == ST_LOAD) ? (ONE_HOT0 << cur_chan_s) : '0;
            busy_r       <= (state_s == ST_LOAD) | (state_s == ST_RUN) | (state_s == ST_CHECK);
            done_r       <= (state_s == ST_DONE);
            if (state_s == ST_LOAD) begin
                gen_period_r   <= period_s;
                gen_duration_r <= period_s >> 1;
            end
        end
    end

    // Window timer, saturating edge counter and pass/fail bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_r      <= '0;
            edge_count_r <= '0;
            pass_mask_r  <= '0;
            fail_mask_r  <= '0;
        end else begin
            if (state_r == ST_LOAD) begin
                timer_r      <= window_s;
                edge_count_r <= '0;
            end else if (state_r == ST_RUN) begin
                timer_r <= timer_r - WIDTH'(1);
                if (rise_s[cur_chan_r] && (edge_count_r != {CNT_W{1'b1}})) begin
                    edge_count_r <= edge_count_r + CNT_W'(1);
                end
            end
            if (start_ok_s) begin
                pass_mask_r <= '0;
                fail_mask_r <= '0;
            end else if ((state_r == ST_CHECK) && !bus.abort) begin
                if (edge_count_r == CNT_W'(PULSES_PER_CH)) begin
                    pass_mask_r[cur_chan_r] <= 1'b1;
                end else begin
                    fail_mask_r[cur_chan_r] <= 1'b1;
                end
            end
        end
    end

    assign bus.gen_enable   = gen_enable_r;
    assign bus.gen_reset    = gen_reset_r;
    assign bus.gen_delay    = {WIDTH{1'b0}};
    assign bus.gen_duration = gen_duration_r;
    assign bus.gen_period   = gen_period_r;
    assign bus.cur_chan     = cur_chan_r;
    assign bus.edge_count   = edge_count_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.pass_mask    = pass_mask_r;
    assign bus.fail_mask    = fail_mask_r;
endmodule

// File: tb/tb_connector_test_sequencer.sv
// Self-checking bench: loopback generator model, fault injection and a
// pass/fail/timing reference model derived from the channel rules.
module tb_connector_test_sequencer;
    localparam int NUM_CH = 8;
    localparam int WIDTH  = 32;
    localparam int KOEF_T = 10;
    localparam int PULSES = 4;
    localparam int SETTLE = 4;
    localparam int CNT_W  = 8;
    localparam int LIMIT  = 3000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    connector_test_sequencer_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    connector_test_sequencer #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .KOEF_T(KOEF_T),
        .PULSES_PER_CH(PULSES), .SETTLE(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [NUM_CH-1:0] stuck_mask = '0;
    logic [NUM_CH-1:0] glitch_mask = '0;
    logic [NUM_CH-1:0] pipe1 = '0;
    logic [NUM_CH-1:0] pipe2 = '0;
    int on_cnt[NUM_CH];
    bit onehot_bad, cfg_bad, stuck_bad, en1_seen;
    int last_count[NUM_CH];

    function automatic int exp_period(input int ch);
        return KOEF_T * (ch + 1);
    endfunction

    function automatic int model_time(input logic [NUM_CH-1:0] en);
        int t = 0;
        for (int i = 0; i < NUM_CH; i++) if (en[i]) t += PULSES * exp_period(i) + SETTLE + 2;
        return t;
    endfunction

    function automatic void model_masks(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] stuck,
                                        input logic [NUM_CH-1:0] glitch,
                                        output logic [NUM_CH-1:0] pm, output logic [NUM_CH-1:0] fm);
        int edges;
        pm = '0;
        fm = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (en[i]) begin
                edges = (stuck[i] ? 0 : PULSES) + (glitch[i] ? 1 : 0);
                if (edges == PULSES) pm[i] = 1'b1; else fm[i] = 1'b1;
            end
        end
    endfunction

    // Generator bank plus cabling: each enabled generator toggles at its period, seen two cycles late.
    always @(negedge clk) begin
        logic [NUM_CH-1:0] gen_out;
        logic [NUM_CH-1:0] sense_v;
        for (int i = 0; i < NUM_CH; i++) begin
            gen_out[i] = bus.gen_enable[i] && ((on_cnt[i] % exp_period(i)) < exp_period(i) / 2);
            sense_v[i] = stuck_mask[i] ? 1'b0 : pipe2[i];
            if (glitch_mask[i] && bus.gen_enable[i] && on_cnt[i] == 40) sense_v[i] = 1'b1;
            if (bus.gen_reset[i]) on_cnt[i] = 0;
            else if (bus.gen_enable[i]) on_cnt[i] = on_cnt[i] + 1;
        end
        bus.sense_in = sense_v;
        pipe2 = pipe1;
        pipe1 = gen_out;
    end

    task automatic clear_flags();
        onehot_bad = 0; cfg_bad = 0; stuck_bad = 0; en1_seen = 0;
        for (int i = 0; i < NUM_CH; i++) last_count[i] = -1;
    endtask

    task automatic monitor();
        if (!$onehot0(bus.gen_enable)) onehot_bad = 1;
        if (bus.gen_enable[1]) en1_seen = 1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.gen_enable[i]) begin
                if (bus.gen_period !== 32'(exp_period(i)) || bus.gen_duration !== 32'(exp_period(i) / 2) ||
                    bus.gen_delay !== 32'd0 || bus.cur_chan !== 3'(i)) cfg_bad = 1;
                if (stuck_mask[i] && bus.edge_count !== 8'd0) stuck_bad = 1;
                last_count[i] = int'(bus.edge_count);
            end
        end
    endtask

    task automatic do_start(input logic [NUM_CH-1:0] en);
        @(negedge clk);
        bus.chan_en = en;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
            monitor();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.gen_enable, bus.gen_reset, bus.busy, bus.done, bus.pass_mask, bus.fail_mask,
             bus.edge_count, bus.cur_chan, bus.gen_period, bus.gen_duration, bus.gen_delay} !== '0)
            begin miscompares++; $display("FAIL reset_outputs: got en=%h rst=%h busy=%b done=%b pm=%h fm=%h, required all 0",
                bus.gen_enable, bus.gen_reset, bus.busy, bus.done, bus.pass_mask, bus.fail_mask); end
        reset = 1'b0;
    endtask

    task automatic test_full_loopback();
        int lat;
        logic [NUM_CH-1:0] pm, fm;
        stuck_mask = '0; glitch_mask = '0; clear_flags();
        do_start(8'hFF);
        wait_done(lat);
        model_masks(8'hFF, stuck_mask, glitch_mask, pm, fm);
        vectors++;
        if (lat !== model_time(8'hFF)) begin miscompares++; $display("FAIL full_latency: got %0d required %0d", lat, model_time(8'hFF)); end
        vectors++;
        if (bus.pass_mask !== pm || bus.fail_mask !== fm) begin miscompares++; $display("FAIL full_masks: got pass=%h fail=%h required pass=%h fail=%h", bus.pass_mask, bus.fail_mask, pm, fm); end
        vectors++;
        if (onehot_bad) begin miscompares++; $display("FAIL full_onehot: gen_enable not one-hot, required one-hot or zero"); end
        vectors++;
        if (cfg_bad) begin miscompares++; $display("FAIL full_config: config bus wrong during RUN, required period/duration/delay/cur_chan of active channel"); end
        for (int i = 0; i < NUM_CH; i++) begin
            vectors++;
            if (last_count[i] !== PULSES) begin miscompares++; $display("FAIL full_count_ch%0d: got %0d required %0d", i, last_count[i], PULSES); end
        end
    endtask

    task automatic test_stuck_ch3();
        int lat;
        logic [NUM_CH-1:0] pm, fm;
        stuck_mask = 8'h08; glitch_mask = '0; clear_flags();
        do_start(8'hFF);
        wait_done(lat);
        model_masks(8'hFF, stuck_mask, glitch_mask, pm, fm);
        vectors++;
        if (bus.pass_mask !== pm || bus.fail_mask !== fm) begin miscompares++; $display("FAIL stuck_masks: got pass=%h fail=%h required pass=%h fail=%h", bus.pass_mask, bus.fail_mask, pm, fm); end
        vectors++;
        if (stuck_bad) begin miscompares++; $display("FAIL stuck_count: edge_count nonzero during ch3 RUN, required 0"); end
        stuck_mask = '0;
    endtask

    task automatic test_glitch_ch5();
        int lat;
        logic [NUM_CH-1:0] pm, fm;
        stuck_mask = '0; glitch_mask = 8'h20; clear_flags();
        do_start(8'hFF);
        wait_done(lat);
        model_masks(8'hFF, stuck_mask, glitch_mask, pm, fm);
        vectors++;
        if (last_count[5] !== PULSES + 1) begin miscompares++; $display("FAIL glitch_count: got %0d required %0d", last_count[5], PULSES + 1); end
        vectors++;
        if (bus.pass_mask !== pm || bus.fail_mask !== fm) begin miscompares++; $display("FAIL glitch_masks: got pass=%h fail=%h required pass=%h fail=%h", bus.pass_mask, bus.fail_mask, pm, fm); end
        glitch_mask = '0;
    endtask

    task automatic test_sparse_enable();
        int lat;
        logic [NUM_CH-1:0] pm, fm;
        clear_flags();
        do_start(8'h05);
        wait_done(lat);
        model_masks(8'h05, stuck_mask, glitch_mask, pm, fm);
        vectors++;
        if (lat !== model_time(8'h05)) begin miscompares++; $display("FAIL sparse_latency: got %0d required %0d", lat, model_time(8'h05)); end
        vectors++;
        if (bus.pass_mask !== pm || bus.fail_mask !== fm) begin miscompares++; $display("FAIL sparse_masks: got pass=%h fail=%h required pass=%h fail=%h", bus.pass_mask, bus.fail_mask, pm, fm); end
        vectors++;
        if (en1_seen) begin miscompares++; $display("FAIL sparse_skip: gen_enable[1] got asserted, required never"); end
    endtask

    task automatic test_abort();
        int n = 0;
        int lat;
        clear_flags();
        do_start(8'hFF);
        while (bus.gen_enable[2] !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        vectors++;
        if (bus.gen_enable[2] !== 1'b1) begin miscompares++; $display("FAIL abort_reach_ch2: got gen_enable=%h required bit 2 set", bus.gen_enable); end
        repeat (20) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        vectors++;
        if ({bus.gen_enable, bus.gen_reset, bus.busy, bus.done} !== '0) begin miscompares++; $display("FAIL abort_outputs: got en=%h rst=%h busy=%b done=%b required all 0", bus.gen_enable, bus.gen_reset, bus.busy, bus.done); end
        vectors++;
        if (bus.pass_mask !== 8'h03 || bus.fail_mask !== 8'h00) begin miscompares++; $display("FAIL abort_masks: got pass=%h fail=%h required pass=03 fail=00", bus.pass_mask, bus.fail_mask); end
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.gen_enable !== '0) begin miscompares++; $display("FAIL abort_stays_idle: got busy=%b en=%h required 0", bus.busy, bus.gen_enable); end
        do_start(8'hFF);
        vectors++;
        if (bus.pass_mask !== '0 || bus.fail_mask !== '0 || bus.cur_chan !== 3'd0 || bus.gen_reset !== 8'h01 || bus.busy !== 1'b1)
            begin miscompares++; $display("FAIL abort_restart: got pass=%h fail=%h chan=%0d rst=%h busy=%b required 00 00 0 01 1", bus.pass_mask, bus.fail_mask, bus.cur_chan, bus.gen_reset, bus.busy); end
        wait_done(lat);
        vectors++;
        if (lat !== model_time(8'hFF) || bus.pass_mask !== 8'hFF) begin miscompares++; $display("FAIL abort_rerun: got lat=%0d pass=%h required %0d FF", lat, bus.pass_mask, model_time(8'hFF)); end
    endtask

    task automatic test_reset_and_busy_start();
        int n = 0;
        int lat;
        do_start(8'hFF);
        while (bus.gen_enable[1] !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        vectors++;
        if (bus.pass_mask !== 8'h01) begin miscompares++; $display("FAIL midrun_mask: got %h required 01", bus.pass_mask); end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({bus.gen_enable, bus.gen_reset, bus.busy, bus.done, bus.pass_mask, bus.fail_mask,
             bus.edge_count, bus.cur_chan, bus.gen_period, bus.gen_duration} !== '0)
            begin miscompares++; $display("FAIL async_reset: got en=%h pm=%h cnt=%0d chan=%0d period=%0d required all 0", bus.gen_enable, bus.pass_mask, bus.edge_count, bus.cur_chan, bus.gen_period); end
        @(negedge clk);
        reset = 1'b0;
        do_start(8'hFF);
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        vectors++;
        if (bus.cur_chan !== 3'd0 || bus.gen_enable !== 8'h01 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL busy_start_state: got chan=%0d en=%h busy=%b required 0 01 1", bus.cur_chan, bus.gen_enable, bus.busy); end
        wait_done(lat);
        vectors++;
        if (lat + 11 !== model_time(8'hFF) || bus.pass_mask !== 8'hFF) begin miscompares++; $display("FAIL busy_start_timing: got lat=%0d pass=%h required %0d FF", lat + 11, bus.pass_mask, model_time(8'hFF)); end
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        vectors++;
        if (bus.done !== 1'b0 || bus.pass_mask !== 8'hFF) begin miscompares++; $display("FAIL idle_before_empty: got done=%b pass=%h required 0 FF", bus.done, bus.pass_mask); end
        do_start(8'h00);
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pass_mask !== '0 || bus.fail_mask !== '0)
            begin miscompares++; $display("FAIL empty_start: got done=%b busy=%b pass=%h fail=%h required 1 0 00 00", bus.done, bus.busy, bus.pass_mask, bus.fail_mask); end
    endtask

    task automatic test_random_passes();
        int lat;
        logic [NUM_CH-1:0] en, pm, fm;
        for (int k = 0; k < 4; k++) begin
            en = NUM_CH'($urandom_range(0, 255));
            stuck_mask = NUM_CH'($urandom) & NUM_CH'($urandom);
            glitch_mask = '0;
            clear_flags();
            do_start(en);
            wait_done(lat);
            model_masks(en, stuck_mask, glitch_mask, pm, fm);
            vectors++;
            if (lat !== model_time(en)) begin miscompares++; $display("FAIL rand%0d_latency: en=%h got %0d required %0d", k, en, lat, model_time(en)); end
            vectors++;
            if (bus.pass_mask !== pm || bus.fail_mask !== fm) begin miscompares++; $display("FAIL rand%0d_masks: en=%h stuck=%h got pass=%h fail=%h required pass=%h fail=%h", k, en, stuck_mask, bus.pass_mask, bus.fail_mask, pm, fm); end
            vectors++;
            if (onehot_bad || cfg_bad) begin miscompares++; $display("FAIL rand%0d_bus: got onehot_bad=%b cfg_bad=%b required 0 0", k, onehot_bad, cfg_bad); end
        end
        stuck_mask = '0;
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) on_cnt[i] = 0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.chan_en = '0;
        bus.sense_in = '0;
        test_reset();
        test_full_loopback();
        test_stuck_ch3();
        test_glitch_ch5();
        test_sparse_enable();
        test_abort();
        test_reset_and_busy_start();
        test_random_passes();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
